// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: byte stream in from the UART receiver, word writes out to instruction memory.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 13
);
    logic              i_Rx_DV;
    logic [7:0]        i_Rx_Byte;
    logic              o_we;
    logic [ADDR_W-1:0] o_addr;
    logic [31:0]       o_wdata;
    modport master (output i_Rx_DV, i_Rx_Byte, input o_we, o_addr, o_wdata);
    modport slave (input i_Rx_DV, i_Rx_Byte, output o_we, o_addr, o_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: packs UART bytes little-endian into 32-bit words and writes them to
// consecutive instruction memory addresses until EOP, address exhaustion or enable drop.
module uart_prog_loader #(
    parameter int          ADDR_W   = 13,
    parameter logic [31:0] EOP_WORD = 32'h00000FFF
) (
    input  logic              i_Clock,
    input  logic              rst_i,
    input  logic              i_en,
    input  logic [15:0]       i_timeout_clks,
    uart_prog_loader_if.slave bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic              o_timeout_err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t            state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_addr;
    logic [15:0]       gap;
    logic [31:0]       shreg;
    logic [31:0]       word;
    logic              last_addr;
    logic              tmo_hit;
    // word is the shift register with the incoming byte merged into its lane
    always_comb begin
        word = shreg;
        word[{byte_cnt, 3'b000} +: 8] = bus.i_Rx_Byte;
    end
    assign last_addr = &word_addr;
    assign tmo_hit   = (i_timeout_clks != 16'd0) && (gap == i_timeout_clks - 16'd1);
    always_ff @(posedge i_Clock or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            word_addr     <= '0;
            gap           <= '0;
            shreg         <= '0;
            bus.o_we      <= 1'b0;
            bus.o_addr    <= '0;
            bus.o_wdata   <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_overflow    <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            bus.o_we <= 1'b0;
            case (state)
                IDLE: begin
                    byte_cnt  <= '0;
                    word_addr <= '0;
                    gap       <= '0;
                    if (i_en) begin
                        state         <= LOAD;
                        o_busy        <= 1'b1;
                        o_overflow    <= 1'b0;
                        o_timeout_err <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!i_en) begin
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                        byte_cnt  <= '0;
                        word_addr <= '0;
                        gap       <= '0;
                        shreg     <= '0;
                    end else if (bus.i_Rx_DV) begin
                        shreg    <= word;
                        byte_cnt <= byte_cnt + 2'd1;
                        gap      <= '0;
                        if (byte_cnt == 2'd3) begin
                            shreg <= '0;
                            if (word == EOP_WORD) begin
                                state  <= DONE;
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                            end else begin
                                bus.o_we    <= 1'b1;
                                bus.o_addr  <= word_addr;
                                bus.o_wdata <= word;
                                // the top address is the final slot; never wrap back to 0
                                if (last_addr) begin
                                    o_overflow <= 1'b1;
                                    state      <= DONE;
                                    o_busy     <= 1'b0;
                                    o_done     <= 1'b1;
                                end else begin
                                    word_addr <= word_addr + 1'b1;
                                end
                            end
                        end
                    end else if (byte_cnt != 2'd0) begin
                        if (tmo_hit) begin
                            byte_cnt      <= '0;
                            gap           <= '0;
                            shreg         <= '0;
                            o_timeout_err <= 1'b1;
                        end else if (gap != 16'hFFFF) begin
                            gap <= gap + 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (!i_en) begin
                        state  <= IDLE;
                        o_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: randomized and directed stimulus against a queue-based loader model,
// with a monitor that scores memory writes and status flags as the DUT presents them.
module tb_uart_prog_loader;
    localparam int          AW   = 2;
    localparam int          MAXW = (1 << AW) - 1;
    localparam logic [31:0] EOP  = 32'h00000FFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] tmo;
    logic        busy, done, ovf, terr;
    int          cyc;
    int          vectors;
    int          errors;
    int          cur_tmo;

    uart_prog_loader_if #(.ADDR_W(AW)) bus ();

    uart_prog_loader #(.ADDR_W(AW), .EOP_WORD(EOP)) dut (
        .i_Clock       (clk),
        .rst_i         (rst),
        .i_en          (en),
        .i_timeout_clks(tmo),
        .bus           (bus),
        .o_busy        (busy),
        .o_done        (done),
        .o_overflow    (ovf),
        .o_timeout_err (terr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int addr; logic [31:0] data; int cyc;} wr_t;
    typedef struct {logic busy; logic done; logic ovf; logic terr;} st_t;
    wr_t wq[$];
    st_t fq[$];

    // reference model: a session is either loading, finished, or idle
    bit         m_load, m_done, m_ovf, m_terr;
    logic [7:0] part[$];
    int         m_addr, m_silent;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_done = 0; m_ovf = 0; m_terr = 0;
        part.delete();
        m_addr = 0; m_silent = 0;
    endtask

    task automatic step(input bit e, input bit dv, input logic [7:0] b);
        logic [31:0] w;
        @(negedge clk);
        en = e;
        tmo = 16'(cur_tmo);
        bus.i_Rx_DV = dv;
        bus.i_Rx_Byte = dv ? b : 8'($urandom);
        if (m_load) begin
            if (!e) begin
                m_load = 0; part.delete(); m_addr = 0;
            end else if (dv) begin
                part.push_back(b);
                m_silent = 0;
                if (part.size() == 4) begin
                    w = {part[3], part[2], part[1], part[0]};
                    part.delete();
                    if (w == EOP) begin
                        m_load = 0; m_done = 1;
                    end else begin
                        wq.push_back('{m_addr, w, cyc + 1});
                        if (m_addr == MAXW) begin
                            m_ovf = 1; m_load = 0; m_done = 1;
                        end else m_addr++;
                    end
                end
            end else if (part.size() != 0) begin
                m_silent++;
                if (cur_tmo != 0 && m_silent == cur_tmo) begin
                    part.delete(); m_terr = 1; m_silent = 0;
                end
            end
        end else if (m_done) begin
            if (!e) m_done = 0;
        end else if (e) begin
            m_load = 1; m_ovf = 0; m_terr = 0; m_addr = 0; m_silent = 0;
            part.delete();
        end
        fq.push_back('{m_load, m_done, m_ovf, m_terr});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) step(1, 1, w[8*i +: 8]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, 32'(bus.o_we), 0);
        chk({tag, "_addr"}, 32'(bus.o_addr), 0);
        chk({tag, "_wdata"}, bus.o_wdata, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ovf"}, 32'(ovf), 0);
        chk({tag, "_terr"}, 32'(terr), 0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        en = 1'b0;
        bus.i_Rx_DV = 1'b0;
        #1;
        chk_all_zero("async_rst");
        chk("pending_writes_at_reset", wq.size(), 0);
        wq.delete();
        fq.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (bus.o_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_we", 32'(bus.o_we), 0);
            end else begin
                chk("we_addr", 32'(bus.o_addr), wq[0].addr);
                chk("we_data", bus.o_wdata, wq[0].data);
                chk("we_cycle", cyc, wq[0].cyc);
                void'(wq.pop_front());
            end
        end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
            chk("missing_we", 32'(bus.o_we), 1);
            void'(wq.pop_front());
        end
        if (fq.size() != 0) begin
            chk("busy", 32'(busy), 32'(fq[0].busy));
            chk("done", 32'(done), 32'(fq[0].done));
            chk("overflow", 32'(ovf), 32'(fq[0].ovf));
            chk("timeout_err", 32'(terr), 32'(fq[0].terr));
            void'(fq.pop_front());
        end
    end

    initial begin
        logic [31:0] w;
        rst = 1'b1; en = 1'b0; tmo = '0; cur_tmo = 0;
        bus.i_Rx_DV = 1'b0; bus.i_Rx_Byte = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // two little-endian words at addresses 0 and 1
        step(1, 0, 8'h00);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        idle(3);
        step(0, 0, 8'h00);

        // write then EOP, then restart at address 0
        step(1, 0, 8'h00);
        send_word(32'hCAFEF00D);
        send_word(EOP);
        idle(3);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        send_word(32'h11223344);
        step(0, 0, 8'h00);

        // timeout boundary: 99 idle cycles survive, 100 discard
        cur_tmo = 100;
        step(1, 0, 8'h00);
        step(1, 1, 8'hAA); step(1, 1, 8'hBB);
        idle(99);
        step(1, 1, 8'hCC); step(1, 1, 8'hDD);
        step(1, 1, 8'hAA); step(1, 1, 8'hBB);
        idle(100);
        send_word(32'h04030201);
        step(0, 0, 8'h00);

        // timeout disabled across a gap longer than the gap counter range
        cur_tmo = 0;
        step(1, 0, 8'h00);
        step(1, 1, 8'hAA); step(1, 1, 8'hBB);
        idle(70000);
        step(1, 1, 8'hCC); step(1, 1, 8'hDD);
        idle(2);
        step(0, 0, 8'h00);

        // address exhaustion: fifth word is ignored
        step(1, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            w = $urandom;
            if (w == EOP) w = w + 1;
            send_word(w);
        end
        idle(3);
        step(0, 0, 8'h00);

        // enable drop mid-word, then async reset mid-word
        step(1, 0, 8'h00);
        step(1, 1, 8'h55); step(1, 1, 8'h66);
        step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        send_word(32'hA5A55A5A);
        step(1, 1, 8'h01); step(1, 1, 8'h02);
        async_reset();

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            cur_tmo = ($urandom % 3 == 0) ? 0 : $urandom_range(1, 12);
            step(1, 0, 8'h00);
            for (int k = 0; k < 60; k++) begin
                int r;
                r = $urandom % 100;
                if (r < 55) step(1, 1, 8'($urandom));
                else if (r < 80) idle($urandom_range(1, 15));
                else if (r < 86) send_word(EOP);
                else if (r < 92) begin
                    repeat ($urandom_range(1, 3)) step(0, 0, 8'h00);
                    step(1, 0, 8'h00);
                end else if (r < 98) cur_tmo = $urandom_range(0, 20);
                else begin
                    async_reset();
                    step(1, 0, 8'h00);
                end
            end
            repeat (2) step(0, 0, 8'h00);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("writes_outstanding", wq.size(), 0);
        chk("status_outstanding", fq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
